uninasoc_irq_ctrl: RTL

Platform-level interrupt controller for UninaSoC that arbitrates the `NUM_IRQ` SoC interrupt sources (3 by default) onto the single external interrupt line of the RVM socket core. Each source has a gateway, a pending bit, an enable bit and a programmable priority. The core claims the winning source ID through a register port and completes it when serviced. The block sits behind the AXI crossbar's register-bridge slave and drives the core's `irq` input.

---
 rtl/uninasoc_irq_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uninasoc_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uninasoc_irq_ctrl
// Function : Gateways, priority arbitration and claim/complete for SoC IRQs.
// Revision : 1.0
// ============================================================================
module uninasoc_irq_ctrl #(
  parameter int NUM_SOURCES = 3,
  parameter int PRIO_WIDTH  = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_SOURCES-1:0] irq_src_i,
  input  logic                   reg_req_i,
  input  logic                   reg_we_i,
  input  logic [7:0]             reg_addr_i,
  input  logic [31:0]            reg_wdata_i,
  output logic [31:0]            reg_rdata_o,
  output logic                   reg_rvalid_o,
  output logic                   irq_o
);

  localparam logic [5:0] c_WORD_PENDING   = 6'h10;
  localparam logic [5:0] c_WORD_ENABLE    = 6'h11;
  localparam logic [5:0] c_WORD_THRESHOLD = 6'h12;
  localparam logic [5:0] c_WORD_CLAIM     = 6'h13;

  // Bit k-1 of each vector belongs to source ID k.
  logic [NUM_SOURCES-1:0] r_pending;
  logic [NUM_SOURCES-1:0] r_in_service;
  logic [NUM_SOURCES-1:0] r_enable;
  logic [PRIO_WIDTH-1:0]  r_prio [NUM_SOURCES];
  logic [PRIO_WIDTH-1:0]  r_threshold;
  logic [31:0]            r_rdata;
  logic                   r_rvalid;
  logic                   r_irq;

  logic [5:0]             w_word;
  logic                   w_wr;
  logic                   w_claim;
  logic                   w_complete;
  logic [3:0]             w_cid;
  logic [3:0]             w_best_id;
  logic [PRIO_WIDTH-1:0]  w_best_prio;
  logic [31:0]            w_rdata;
  logic [NUM_SOURCES-1:0] w_pending_nxt;
  logic [NUM_SOURCES-1:0] w_in_service_nxt;
  logic                   w_unused_bits;

  assign w_word        = reg_addr_i[7:2];
  assign w_wr          = reg_req_i & reg_we_i;
  assign w_claim       = reg_req_i & ~reg_we_i & (w_word == c_WORD_CLAIM);
  assign w_complete    = w_wr & (w_word == c_WORD_CLAIM);
  assign w_cid         = reg_wdata_i[3:0];
  assign w_unused_bits = ^{reg_addr_i[1:0], reg_wdata_i};

  // Seeding the running best with THRESHOLD enforces PRIO > THRESHOLD, and the
  // strict compare keeps the lowest ID on ties.
  always_comb begin
    w_best_id   = '0;
    w_best_prio = r_threshold;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      if (r_pending[k] && r_enable[k] && (r_prio[k] > w_best_prio)) begin
        w_best_prio = r_prio[k];
        w_best_id   = 4'(k + 1);
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (!reg_we_i) begin
      case (w_word)
        c_WORD_PENDING:   w_rdata[NUM_SOURCES:0] = {r_pending, 1'b0};
        c_WORD_ENABLE:    w_rdata[NUM_SOURCES:0] = {r_enable, 1'b0};
        c_WORD_THRESHOLD: w_rdata[PRIO_WIDTH-1:0] = r_threshold;
        c_WORD_CLAIM:     w_rdata[3:0] = w_best_id;
        default: begin
          for (int k = 0; k < NUM_SOURCES; k++) begin
            if (w_word == 6'(k + 1)) w_rdata[PRIO_WIDTH-1:0] = r_prio[k];
          end
        end
      endcase
    end
  end

  // A claimed source is already pending, so the gateway cannot re-pend it in
  // the claim cycle; the claim's clear is applied last regardless.
  always_comb begin
    w_pending_nxt    = r_pending | (irq_src_i & ~r_in_service);
    w_in_service_nxt = r_in_service;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      if (w_claim && (w_best_id == 4'(k + 1))) begin
        w_pending_nxt[k]    = 1'b0;
        w_in_service_nxt[k] = 1'b1;
      end
      if (w_complete && (w_cid == 4'(k + 1))) begin
        w_in_service_nxt[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pending    <= '0;
      r_in_service <= '0;
      r_enable     <= '0;
      r_threshold  <= '0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
      r_irq        <= 1'b0;
      for (int k = 0; k < NUM_SOURCES; k++) begin
        r_prio[k] <= '0;
      end
    end else begin
      r_pending    <= w_pending_nxt;
      r_in_service <= w_in_service_nxt;
      r_irq        <= (w_best_id != 4'd0);
      r_rvalid     <= reg_req_i;
      if (reg_req_i) begin
        r_rdata <= w_rdata;
      end
      if (w_wr && (w_word == c_WORD_ENABLE)) begin
        r_enable <= reg_wdata_i[NUM_SOURCES:1];
      end
      if (w_wr && (w_word == c_WORD_THRESHOLD)) begin
        r_threshold <= reg_wdata_i[PRIO_WIDTH-1:0];
      end
      for (int k = 0; k < NUM_SOURCES; k++) begin
        if (w_wr && (w_word == 6'(k + 1))) begin
          r_prio[k] <= reg_wdata_i[PRIO_WIDTH-1:0];
        end
      end
    end
  end

  assign reg_rdata_o  = r_rdata;
  assign reg_rvalid_o = r_rvalid;
  assign irq_o        = r_irq;

endmodule
`default_nettype wire
